// File: rtl/priority_code_pkg.sv
// Shared definitions for the priority-code receive path.
//   - state_t  : decoder control states
//   - CODE_W   : width of the active-low encoder code
//   - OUT_W    : width of the active-low one-hot output
//   - OUT_IDLE : output pattern when no line is asserted
package priority_code_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;
  localparam logic [OUT_W-1:0] OUT_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    HOLD    = 2'd2,
    WAITREL = 2'd3
  } state_t;

  // Larger of two integers, used for sizing counters at elaboration.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/priority_code_decoder_onehot.sv
// Purely combinational 3-to-8 decoder with active-low output.
// Ports:
//   i_idx       : channel index (0..7)
//   o_onehot_n  : all ones except a zero at bit i_idx
module code_to_onehot_n
  import priority_code_pkg::*;
(
  input  logic [CODE_W-1:0] i_idx,
  output logic [OUT_W-1:0]  o_onehot_n
);

  always_comb begin
    o_onehot_n        = OUT_IDLE;
    o_onehot_n[i_idx] = 1'b0;
  end

endmodule

// File: rtl/priority_code_decoder.sv
// Receive side of an 8-to-3 priority-encoder link. A request (EN low and
// GS low) is qualified by requiring STABLE_CYCLES consecutive identical
// code samples, then one active-low line is driven for HOLD_CYCLES clocks.
// Afterwards the request must be withdrawn before another can fire.
// Ports:
//   CLK     : clock, all state on rising edge
//   RST     : synchronous reset, active-high
//   EN      : active-low enable; high forces idle / aborts a pulse
//   GS      : active-low group select; low means a request is present
//   CodeIn  : active-low code, channel index = ~CodeIn
//   DataOut : active-low one-hot output, 8'hFF when inactive
//   Valid   : high while DataOut carries a decoded line
//   Busy    : high in every state except IDLE
module priority_code_decoder
  import priority_code_pkg::*;
#(
  parameter int STABLE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              GS,
  input  logic [CODE_W-1:0] CodeIn,
  output logic [OUT_W-1:0]  DataOut,
  output logic              Valid,
  output logic              Busy
);

  // Counters only ever hold values below max(STABLE, HOLD); the extra bit
  // keeps the width legal when both parameters are 1.
  localparam int CNT_W = $clog2(max2(STABLE_CYCLES, HOLD_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_qcnt;
  logic [CNT_W-1:0]    w_qcnt_nxt;
  logic [CNT_W-1:0]    r_hcnt;
  logic [CNT_W-1:0]    w_hcnt_nxt;
  logic [CODE_W-1:0]   r_cand;
  logic [CODE_W-1:0]   w_cand_nxt;
  logic [CODE_W-1:0]   r_idx;
  logic [CODE_W-1:0]   w_idx_nxt;
  logic                w_req;
  logic [OUT_W-1:0]    w_onehot_n;

  assign w_req = ~EN & ~GS;

  // ---- next-state / counter logic ----
  always_comb begin
    w_state_nxt = r_state;
    w_qcnt_nxt  = r_qcnt;
    w_hcnt_nxt  = r_hcnt;
    w_cand_nxt  = r_cand;
    w_idx_nxt   = r_idx;

    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_cand_nxt = CodeIn;
          if (STABLE_CYCLES == 1) begin
            w_state_nxt = HOLD;
            w_idx_nxt   = ~CodeIn;
            w_hcnt_nxt  = HOLD_LOAD;
          end else begin
            w_state_nxt = QUAL;
            w_qcnt_nxt  = CNT_ONE;
          end
        end
      end

      QUAL: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
        end else if (CodeIn != r_cand) begin
          // A code change restarts qualification, even on the edge that
          // would otherwise have fired.
          w_cand_nxt = CodeIn;
          w_qcnt_nxt = CNT_ONE;
        end else if (r_qcnt == QUAL_LAST) begin
          w_state_nxt = HOLD;
          w_idx_nxt   = ~r_cand;
          w_hcnt_nxt  = HOLD_LOAD;
        end else begin
          w_qcnt_nxt = r_qcnt + CNT_ONE;
        end
      end

      HOLD: begin
        // GS/CodeIn are deliberately ignored here; only EN can cut the pulse.
        if (EN) begin
          w_state_nxt = IDLE;
        end else if (r_hcnt == CNT_ZERO) begin
          w_state_nxt = WAITREL;
        end else begin
          w_hcnt_nxt = r_hcnt - CNT_ONE;
        end
      end

      WAITREL: begin
        if (GS || EN) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---- state registers ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_qcnt  <= '0;
      r_hcnt  <= '0;
      r_cand  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_qcnt  <= w_qcnt_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_cand  <= w_cand_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // ---- output decode (registers only) ----
  code_to_onehot_n u_onehot (
    .i_idx      (r_idx),
    .o_onehot_n (w_onehot_n)
  );

  assign Valid   = (r_state == HOLD);
  assign Busy    = (r_state != IDLE);
  assign DataOut = Valid ? w_onehot_n : OUT_IDLE;

endmodule
